hilbert_seq_ctrl: RTL and testbench

//  Sequencer for the serial 8th-order Hilbert filter core on one hydrophone channel.

---
 rtl/hilbert_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hilbert_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilbert_seq_ctrl.sv
// Sequencer for a serial Hilbert filter core: buffers ADC samples in a FIFO, issues one load per sample,
// captures (re, im) and hands it downstream with valid/ready. Optional HILBERT_SEQ_DROP_CNT_EN adds drop_cnt.
`timescale 1ns/1ps
module hilbert_seq_ctrl #(
  parameter int XW          = 16,
  parameter int YW          = 28,
  parameter int FIFO_DEPTH  = 4,
  parameter int CALC_CYCLES = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [XW-1:0] in_data,
  output logic          hf_enable,
  output logic [XW-1:0] hf_xin,
  input  logic [YW-1:0] hf_re,
  input  logic [YW-1:0] hf_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [YW-1:0] out_re,
  output logic [YW-1:0] out_im,
  output logic          ovf,
  input  logic          clr_ovf
`ifdef HILBERT_SEQ_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CALC_CYCLES);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_LD  = CW'(CALC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          out_valid_q, out_valid_d;
  logic [YW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic          ovf_q, ovf_d;
  logic          full_s, empty_s, push_s, pop_s, drop_s;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full_s  = (count_q == CNT_FULL);
  assign empty_s = (count_q == {(AW+1){1'b0}});
  assign pop_s   = (state_q == ISSUE);
  assign push_s  = in_valid && (!full_s || pop_s);
  assign drop_s  = in_valid && full_s && !pop_s;

  assign hf_enable = pop_s;
  assign hf_xin    = pop_s ? mem_q[rd_ptr_q] : {XW{1'b0}};
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign ovf       = ovf_q;

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Sequencer next state, wait counter and result capture.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    case (state_q)
      IDLE: begin
        if (!empty_s) state_d = ISSUE;
        else          state_d = IDLE;
      end
      ISSUE: begin
        wait_d  = WAIT_LD;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == {CW{1'b0}}) begin
          out_re_d    = hf_re;
          out_im_d    = hf_im;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (count_d != {(AW+1){1'b0}}) state_d = ISSUE;
          else                           state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop in the clear cycle keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop_s)       ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // Control and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {(AW+1){1'b0}};
      wait_q      <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_re_q    <= {YW{1'b0}};
      out_im_q    <= {YW{1'b0}};
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      ovf_q       <= ovf_d;
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Sample storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clock) begin
    if (push_s) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef HILBERT_SEQ_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter, cleared together with the sticky flag.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf)                                drop_cnt_d = drop_s ? 16'd1 : 16'd0;
    else if (drop_s && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    else                                        drop_cnt_d = drop_cnt_q;
  end

  // Drop counter register.
  always_ff @(posedge clock) begin
    if (reset) drop_cnt_q <= 16'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  // Without the counter only the sticky ovf flag reports drops.
`endif

endmodule

// File: tb/tb_hilbert_seq_ctrl.sv
// Directed bench for hilbert_seq_ctrl with a stand-in filter core whose outputs drift every cycle,
// so a capture on the wrong edge shows up in out_re/out_im.
`timescale 1ns/1ps
module tb_hilbert_seq_ctrl;
  localparam int XW = 16;
  localparam int YW = 28;
  localparam int CALC = 10;

  logic          clock = 1'b0;
  logic          reset, in_valid, out_ready, clr_ovf;
  logic [XW-1:0] in_data;
  logic          hf_enable, out_valid, ovf;
  logic [XW-1:0] hf_xin;
  logic [YW-1:0] hf_re, hf_im, out_re, out_im;
`ifdef HILBERT_SEQ_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int total = 0;
  int bad = 0;
  int n;
  int cyc = 0;
  int en_in_hold = 0;
  logic [XW-1:0] xin_q[$];
  int            tpl_q[$];
  logic [YW-1:0] res_re_q[$], res_im_q[$];
  logic [XW-1:0] cx;
  logic [7:0]    ck;

  hilbert_seq_ctrl #(.XW(XW), .YW(YW), .FIFO_DEPTH(4), .CALC_CYCLES(CALC)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .hf_enable(hf_enable), .hf_xin(hf_xin), .hf_re(hf_re), .hf_im(hf_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .ovf(ovf), .clr_ovf(clr_ovf)
`ifdef HILBERT_SEQ_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Stand-in core: latches the loaded sample, outputs move by one each cycle after the load.
  always @(posedge clock) begin
    if (reset) begin
      cx <= '0;
      ck <= 8'd0;
    end else if (hf_enable) begin
      cx <= hf_xin;
      ck <= 8'd0;
    end else if (ck != 8'hFF) begin
      ck <= ck + 8'd1;
    end
  end
  assign hf_re = {{(YW-XW){cx[XW-1]}}, cx} + YW'(ck);
  assign hf_im = ({{(YW-XW){cx[XW-1]}}, cx} << 4) - YW'(ck);

  // Record loads and delivered results on the edge that takes them.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (hf_enable) begin
      xin_q.push_back(hf_xin);
      tpl_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      res_re_q.push_back(out_re);
      res_im_q.push_back(out_im);
    end
    if (hf_enable && out_valid) en_in_hold <= en_in_hold + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [YW-1:0] exp_re(input logic [XW-1:0] x);
    return {{(YW-XW){x[XW-1]}}, x} + YW'(CALC - 1);
  endfunction

  function automatic logic [YW-1:0] exp_im(input logic [XW-1:0] x);
    return ({{(YW-XW){x[XW-1]}}, x} << 4) - YW'(CALC - 1);
  endfunction

  function automatic logic [XW-1:0] get_xin(input int i);
    if (i < xin_q.size()) return xin_q[i];
    return 'x;
  endfunction

  function automatic logic [YW-1:0] get_res_re(input int i);
    if (i < res_re_q.size()) return res_re_q[i];
    return 'x;
  endfunction

  function automatic logic [YW-1:0] get_res_im(input int i);
    if (i < res_im_q.size()) return res_im_q[i];
    return 'x;
  endfunction

  function automatic int get_tpl(input int i);
    if (i < tpl_q.size()) return tpl_q[i];
    return -1000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    xin_q.delete();
    tpl_q.delete();
    res_re_q.delete();
    res_im_q.delete();
  endtask

  task automatic wait_valid(input int limit, output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < limit) begin
      @(negedge clock);
      cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_ovf = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_hf_enable", hf_enable, 1'b0);
    chk("rst_hf_xin", hf_xin, 16'h0000);
    chk("rst_out_re", out_re, 28'h0);
    chk("rst_out_im", out_im, 28'h0);
    chk("rst_ovf", ovf, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Single sample, ready high.
    clear_logs();
    in_valid = 1'b1; in_data = 16'h1000;
    @(negedge clock);
    in_valid = 1'b0;
    wait_valid(40, n);
    chk("t1_latency", n, 12);
    chk("t1_out_re", out_re, 28'h0001009);
    chk("t1_out_im", out_im, 28'h000FFF7);
    repeat (3) @(negedge clock);
    chk("t1_valid_drop", out_valid, 1'b0);
    chk("t1_pulses", xin_q.size(), 1);
    chk("t1_xin", get_xin(0), 16'h1000);

    // Four back-to-back samples.
    clear_logs();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = XW'(i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (60) @(negedge clock);
    chk("t2_pulses", xin_q.size(), 4);
    chk("t2_results", res_re_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_xin%0d", i), get_xin(i), XW'(i + 1));
      chk($sformatf("t2_re%0d", i), get_res_re(i), exp_re(XW'(i + 1)));
      chk($sformatf("t2_im%0d", i), get_res_im(i), exp_im(XW'(i + 1)));
    end
    for (int i = 1; i < 4; i++) chk($sformatf("t2_gap%0d", i), get_tpl(i) - get_tpl(i - 1), 12);
    chk("t2_ovf", ovf, 1'b0);

    // Six back-to-back samples overflow the 4-deep FIFO once.
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 16'h0010 + XW'(i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("t3_ovf_set", ovf, 1'b1);
`ifdef HILBERT_SEQ_DROP_CNT_EN
    chk("t3_drop_cnt", drop_cnt, 16'd1);
`endif
    repeat (70) @(negedge clock);
    chk("t3_pulses", xin_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t3_xin%0d", i), get_xin(i), 16'h0010 + XW'(i));
    chk("t3_ovf_sticky", ovf, 1'b1);
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", ovf, 1'b0);
`ifdef HILBERT_SEQ_DROP_CNT_EN
    chk("t3_drop_cnt_clr", drop_cnt, 16'd0);
`endif

    // Downstream stalls with a second sample queued.
    clear_logs();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0123;
    @(negedge clock);
    in_data = 16'h7FFF;
    @(negedge clock);
    in_valid = 1'b0;
    wait_valid(40, n);
    chk("t4_latency", n, 11);
    chk("t4_re0", out_re, exp_re(16'h0123));
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_re", out_re, exp_re(16'h0123));
      chk("t4_hold_im", out_im, exp_im(16'h0123));
    end
    chk("t4_no_reload", xin_q.size(), 1);
    out_ready = 1'b1;
    @(negedge clock);
    wait_valid(40, n);
    chk("t4_latency2", n, 11);
    chk("t4_re1", out_re, exp_re(16'h7FFF));
    chk("t4_im1", out_im, exp_im(16'h7FFF));
    chk("t4_pulses", xin_q.size(), 2);
    chk("t4_xin1", get_xin(1), 16'h7FFF);
    @(negedge clock);

    // Reset while computing, with the FIFO full and ovf set.
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 16'h0020 + XW'(i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("t5_pre_ovf", ovf, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_enable", hf_enable, 1'b0);
    chk("t5_rst_ovf", ovf, 1'b0);
`ifdef HILBERT_SEQ_DROP_CNT_EN
    chk("t5_rst_drop_cnt", drop_cnt, 16'd0);
`endif
    reset = 1'b0;
    clear_logs();
    repeat (20) @(negedge clock);
    chk("t5_fifo_empty", xin_q.size(), 0);
    chk("t5_idle_valid", out_valid, 1'b0);
    in_valid = 1'b1; in_data = 16'h0ABC;
    @(negedge clock);
    in_valid = 1'b0;
    wait_valid(40, n);
    chk("t5_latency", n, 12);
    chk("t5_re", out_re, exp_re(16'h0ABC));
    chk("t5_pulses", xin_q.size(), 1);
    @(negedge clock);

    // Push into a full FIFO during the ISSUE cycle.
    clear_logs();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = XW'(i) << 8;
      @(negedge clock);
    end
    in_valid = 1'b0;
    wait_valid(40, n);
    chk("t6_wait", n < 40, 1'b1);
    chk("t6_ovf_pre", ovf, 1'b0);
    out_ready = 1'b1;
    @(negedge clock);
    chk("t6_issue", hf_enable, 1'b1);
    in_valid = 1'b1; in_data = 16'h8001;
    @(negedge clock);
    in_valid = 1'b0;
    chk("t6_ovf_after", ovf, 1'b0);
    repeat (75) @(negedge clock);
    chk("t6_pulses", xin_q.size(), 6);
    for (int i = 0; i < 5; i++) chk($sformatf("t6_xin%0d", i), get_xin(i), XW'(i + 1) << 8);
    chk("t6_xin5", get_xin(5), 16'h8001);
    chk("t6_results", res_re_q.size(), 6);
    chk("t6_re_neg", get_res_re(5), 28'hFFF800A);
    chk("t6_im_neg", get_res_im(5), 28'hFF80007);
    chk("t6_ovf_end", ovf, 1'b0);

    chk("load_during_hold", en_in_hold, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
